// File: rtl/lcd_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_timer
// Brief    : HD44780-class write-cycle generator (setup, enable, hold, exec wait)
// Revision : 1.0
// ============================================================================
module lcd_bus_timer #(
  parameter int T_SETUP = 3,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 3,
  parameter int T_EXEC  = 2500,
  parameter int T_CLEAR = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] idata,
  input  logic       irs,
  input  logic       istart,
  output logic       odone,
  output logic       obusy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int CNT_MAX_A = (T_CLEAR > T_EXEC) ? T_CLEAR : T_EXEC;
  localparam int CNT_MAX   = (CNT_MAX_A > T_EN) ? CNT_MAX_A : T_EN;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EN_HI = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             long_wait;
  logic             start_edge;
  logic             accept;
  logic             is_clear_home;

  assign start_edge    = istart & ~start_q;
  assign accept        = (state == IDLE) && start_edge;
  assign is_clear_home = ~irs && (idata >= 8'h01) && (idata <= 8'h03);
  assign lcd_rw        = 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = SETUP;
      SETUP:   if (cnt == SETUP_LAST) state_nxt = EN_HI;
      EN_HI:   if (cnt == EN_LAST) state_nxt = HOLD;
      HOLD:    if (cnt == HOLD_LAST) state_nxt = EXEC;
      EXEC:    if (cnt == (long_wait ? CLEAR_LAST : EXEC_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= istart;
      // Counter restarts on every state entry and idles at zero.
      if (state_nxt != state || state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pin-facing outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      odone  <= 1'b0;
      obusy  <= 1'b0;
      lcd_en <= 1'b0;
    end else begin
      odone  <= (state_nxt == DONE);
      obusy  <= (state_nxt != IDLE);
      lcd_en <= (state_nxt == EN_HI);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      long_wait <= 1'b0;
    end else if (accept) begin
      lcd_data  <= idata;
      lcd_rs    <= irs;
      long_wait <= is_clear_home;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_timer
// Brief    : Self-checking bench for lcd_bus_timer against a timeline model
// Revision : 1.0
// ============================================================================
module tb_lcd_bus_timer;

  localparam int T_SETUP = 3;
  localparam int T_EN    = 25;
  localparam int T_HOLD  = 3;
  localparam int T_EXEC  = 200;
  localparam int T_CLEAR = 700;
  localparam int LAT_N   = 1 + T_SETUP + T_EN + T_HOLD + T_EXEC;
  localparam int LAT_L   = 1 + T_SETUP + T_EN + T_HOLD + T_CLEAR;

  logic       clk;
  logic       rst;
  logic [7:0] idata;
  logic       irs;
  logic       istart;
  logic       odone;
  logic       obusy;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  lcd_bus_timer #(
    .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk), .rst(rst), .idata(idata), .irs(irs), .istart(istart),
    .odone(odone), .obusy(obusy), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Timeline model: a transaction accepted at posedge t makes every output a
  // pure function of how many posedges have elapsed since t.
  int       cyc = 0;
  logic     m_active = 1'b0;
  int       m_tstart = 0;
  int       m_lat = 0;
  logic [7:0] m_data = 8'h00;
  logic     m_rs = 1'b0;
  logic     m_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active <= 1'b0;
      m_data   <= 8'h00;
      m_rs     <= 1'b0;
      m_prev   <= 1'b0;
    end else begin
      if (istart && !m_prev && (!m_active || (cyc + 1 - m_tstart) >= m_lat + 1)) begin
        m_active <= 1'b1;
        m_tstart <= cyc + 1;
        m_data   <= idata;
        m_rs     <= irs;
        m_lat    <= 1 + T_SETUP + T_EN + T_HOLD +
                    ((!irs && idata >= 8'h01 && idata <= 8'h03) ? T_CLEAR : T_EXEC);
      end
      m_prev <= istart;
    end
  end

  int   en_rise_cnt = 0;
  int   en_rise_cyc = 0;
  int   en_width = 0;
  int   en_run = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic en_prev = 1'b0;
  int   d;
  logic e_busy, e_en, e_done;

  always @(negedge clk) begin
    if (cyc > 0) begin
      d      = cyc - m_tstart;
      e_busy = m_active && (d <= m_lat - 1);
      e_en   = m_active && (d >= T_SETUP) && (d < T_SETUP + T_EN);
      e_done = m_active && (d == m_lat - 1);
      checks++;
      if (obusy === e_busy && lcd_en === e_en && odone === e_done &&
          lcd_data === m_data && lcd_rs === m_rs && lcd_rw === 1'b0)
        passes++;
      else
        $display("FAIL cycle_%0d: got busy=%b en=%b done=%b data=%h rs=%b rw=%b expected busy=%b en=%b done=%b data=%h rs=%b rw=0",
                 cyc, obusy, lcd_en, odone, lcd_data, lcd_rs, lcd_rw,
                 e_busy, e_en, e_done, m_data, m_rs);
    end
    if (lcd_en && !en_prev) begin
      en_rise_cnt++;
      en_rise_cyc = cyc;
      en_run = 0;
    end
    if (lcd_en) en_run++;
    if (!lcd_en && en_prev) en_width = en_run;
    en_prev = lcd_en;
    if (odone) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < max_cyc) begin
      step(1);
      i++;
    end
    if (done_cnt == d0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_tx(input string name, input logic rs, input logic [7:0] data,
                       input int exp_lat);
    int k;
    istart = 1'b0;
    step(2);
    k = cyc;
    irs = rs; idata = data; istart = 1'b1;
    wait_done(name, exp_lat + 50);
    chk(name, done_cyc - k, exp_lat);
  endtask

  int k0, e0, dn0;

  initial begin
    rst = 1'b1; istart = 1'b0; idata = 8'h00; irs = 1'b0;
    step(3);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_busy", int'(obusy), 0);
    chk("rst_done", int'(odone), 0);
    chk("rst_data", int'(lcd_data), 0);
    rst = 1'b0;
    step(2);

    // Character write held high, with idata disturbed during the enable pulse.
    k0 = cyc; e0 = en_rise_cnt;
    irs = 1'b1; idata = 8'h41; istart = 1'b1;
    step(10);
    idata = 8'hFF;
    wait_done("lat_char", LAT_N + 50);
    chk("lat_char", done_cyc - k0, 232);
    chk("en_rise_ofs", en_rise_cyc - k0, 4);
    chk("en_width", en_width, 25);
    chk("char_rs", int'(lcd_rs), 1);
    step(40);
    chk("no_retrigger", en_rise_cnt - e0, 1);
    chk("idle_busy", int'(obusy), 0);
    chk("data_kept", int'(lcd_data), 8'h41);

    do_tx("lat_clear01", 1'b0, 8'h01, 732);
    do_tx("lat_cmd38", 1'b0, 8'h38, 232);
    do_tx("lat_home03", 1'b0, 8'h03, 732);
    do_tx("lat_data02", 1'b1, 8'h02, LAT_N);
    do_tx("lat_cmd04", 1'b0, 8'h04, LAT_N);

    // Start toggles during the exec wait must be ignored.
    istart = 1'b0; step(2);
    e0 = en_rise_cnt; dn0 = done_cnt;
    irs = 1'b0; idata = 8'h38; istart = 1'b1;
    step(40);
    repeat (60) begin
      istart = ~istart;
      step(1);
    end
    istart = 1'b0;
    step(LAT_N);
    chk("toggle_en_pulses", en_rise_cnt - e0, 1);
    chk("toggle_done", done_cnt - dn0, 1);

    // Back-to-back: drop on odone, raise the next cycle.
    irs = 1'b1; idata = 8'h41; istart = 1'b1;
    for (int i = 0; i < LAT_N + 50 && !odone; i++) step(1);
    chk("b2b_first_done", int'(odone), 1);
    istart = 1'b0;
    step(1);
    k0 = cyc;
    irs = 1'b0; idata = 8'h0C; istart = 1'b1;
    wait_done("b2b", LAT_N + 50);
    chk("b2b_lat", done_cyc - k0, 232);
    chk("b2b_en_ofs", en_rise_cyc - k0, 4);
    chk("b2b_data", int'(lcd_data), 8'h0C);

    // Reset during the enable pulse aborts without odone.
    istart = 1'b0; step(2);
    irs = 1'b0; idata = 8'h38; istart = 1'b1;
    step(10);
    rst = 1'b1; istart = 1'b0;
    step(1);
    chk("abort_en", int'(lcd_en), 0);
    chk("abort_busy", int'(obusy), 0);
    chk("abort_data", int'(lcd_data), 0);
    step(2);
    rst = 1'b0;
    dn0 = done_cnt;
    step(LAT_L + 20);
    chk("abort_no_done", done_cnt - dn0, 0);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(7) == 0) istart = ~istart;
      if ($urandom_range(3) == 0) begin
        idata = ($urandom_range(2) == 0) ? 8'($urandom_range(4)) : 8'($urandom);
        irs   = 1'($urandom);
      end
      if ($urandom_range(3999) == 0) begin
        rst = 1'b1;
        step($urandom_range(3, 1));
        rst = 1'b0;
      end
      step(1);
    end
    istart = 1'b0;
    step(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
